rc4_prga_decrypt: RTL and testbench
===================================

Name: rc4_prga_decrypt

Overview:
- Downstream consumer of the encrypted-message register file, which holds 32 ciphertext bytes.
- Runs the RC4 PRGA over an already key-scheduled S-box RAM, XORs each keystream byte with the matching ciphertext byte, and writes plaintext to a decrypted-message RAM.
- Flags whether every plaintext byte is a legal character (lowercase a–z or space), so the key-search controller can accept or reject the current key.

Parameters:
MSG_LEN, 32, number of ciphertext bytes processed per run
DATA_W, 8, byte width of S, ciphertext and plaintext
K_W, 5, width of message index (clog2 of MSG_LEN)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a run when idle or done
enc_index  out  K_W  index into ciphertext register file (combinational read)
enc_data  in  DATA_W  ciphertext byte at enc_index, valid same cycle
s_address  out  8  S RAM address
s_data  out  DATA_W  S RAM write data
s_wren  out  1  S RAM write enable
s_q  in  DATA_W  S RAM read data, valid the cycle after address is presented
dec_address  out  K_W  plaintext RAM address
dec_data  out  DATA_W  plaintext byte
dec_wren  out  1  plaintext RAM write enable
busy  out  1  high from the first RD_I through the final NEXT
done  out  1  level; high in DONE until the next start
key_valid  out  1  valid only while done=1; 1 means all written bytes are legal

Behaviour:
- Reset (async): state=IDLE; i, j, k, si, sj, f registers = 0; all outputs = 0.
- start in IDLE or DONE:
  - Load i=1, j=0, k=0, valid_acc=1.
  - Next state is RD_I; done drops in that same cycle.
- start while busy: ignored.
- Per-byte sequence, 9 cycles:
  - RD_I: s_address=i.
  - WT_I: si<=s_q; j<=j+s_q (mod 256).
  - RD_J: s_address=j.
  - WT_J: sj<=s_q.
  - WR_J: s_address=j, s_data=si, s_wren=1.
  - WR_I: s_address=i, s_data=sj, s_wren=1.
  - RD_F: s_address=si+sj (mod 256).
  - WT_F:
    - f=s_q.
    - dec_address=k, dec_data=f^enc_data, dec_wren=1 (enc_index=k throughout the byte).
    - valid_acc<=valid_acc & legal(f^enc_data).
  - NEXT: if k==MSG_LEN-1 go to DONE; else i<=i+1, k<=k+1, go to RD_I.
- Total latency:
  - start pulse to done=1 is 1+9·MSG_LEN cycles (289 for MSG_LEN=32).
- DONE: done=1, key_valid=valid_acc; both held until the next start.
- Outputs outside their active states:
  - s_wren and dec_wren are 0 outside WR_J/WR_I/WT_F.
  - s_address, dec_address and data are don't-care when the enable is low, but are driven to 0.
- Arithmetic:
  - i, j and si+sj are 8-bit and wrap mod 256 with no carry.
  - k never exceeds MSG_LEN-1.
- i==j case:
  - WR_J then WR_I both write the same location.
  - The final value is sj, which equals si, so the swap is a no-op, as RC4 requires.
- Legal character: 8'h61..8'h7A inclusive, or 8'h20. All other values are illegal.
- reset asserted mid-run: immediate return to IDLE. Partial S and plaintext RAM contents are left as-is. done=0.

Optional Feature:
RC4_EARLY_ABORT_EN
- Defined: in WT_F, an illegal byte still writes dec RAM, then the block goes straight to DONE with key_valid=0. This skips the remaining bytes and speeds up the key search.
- Undefined: all MSG_LEN bytes are always processed, and key_valid is the AND over all of them.

Decomposition:
- Package rc4_pkg: state enum type (IDLE, RD_I, WT_I, RD_J, WT_J, WR_J, WR_I, RD_F, WT_F, NEXT, DONE); MSG_LEN default; constants CHAR_A=8'h61, CHAR_Z=8'h7A, CHAR_SPACE=8'h20.
- One sub-module rc4_valid_char: combinational byte→legal check, reused by the key-search controller.

Test Plan:
1. S RAM model initialised S[x]=x, ciphertext all 0x00, start pulse:
   - dec[0]=0x02, dec[1]=0x05; after byte 1, S[2]=0x03 and S[3]=0x02.
   - key_valid=0; done rises exactly 289 cycles after start.
2. Ciphertext precomputed as keystream XOR "attack at dawn..." (32 legal bytes) for the identity S:
   - All dec bytes match the plaintext; key_valid=1.
3. Same as 2 with byte 5 XORed to give 0x41 ('A'):
   - Macro undefined: key_valid=0, done at 289 cycles.
   - Macro defined: done after 1+9·6 = 55 cycles, key_valid=0, dec[6..31] untouched.
4. Assert reset during byte 10:
   - All outputs 0 in the same cycle.
   - A fresh start restarts from i=1, j=0; the result is correct for the S contents present at restart.
5. Pulse start during byte 3: ignored, byte sequence and latency unchanged.
6. Pulse start in DONE: done drops next cycle, a second run completes, and key_valid is recomputed.

Source files
------------

// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared states, sizes and legal-character constants for the RC4 decrypt path
package rc4_pkg;

    localparam int MSG_LEN_DEFAULT = 32;

    localparam logic [7:0] CHAR_A     = 8'h61;
    localparam logic [7:0] CHAR_Z     = 8'h7A;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [3:0] {
        IDLE,
        RD_I,
        WT_I,
        RD_J,
        WT_J,
        WR_J,
        WR_I,
        RD_F,
        WT_F,
        NEXT,
        DONE
    } rc4_state_e;

endpackage

// File: rtl/rc4_valid_char.sv
// rtl/rc4_valid_char.sv - combinational check that a byte is lowercase a-z or space
module rc4_valid_char
    import rc4_pkg::*;
(
    input  logic [7:0] char_in,
    output logic       legal
);

    assign legal = ((char_in >= CHAR_A) && (char_in <= CHAR_Z)) || (char_in == CHAR_SPACE);

endmodule

// File: rtl/rc4_prga_decrypt.sv
// rtl/rc4_prga_decrypt.sv - RC4 PRGA over a key-scheduled S RAM, XOR-decrypt into plaintext RAM
// Optional feature macro: RC4_EARLY_ABORT_EN (stop at the first illegal plaintext byte)
module rc4_prga_decrypt
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEFAULT,
    parameter int DATA_W  = 8,
    parameter int K_W     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [K_W-1:0]    enc_index,
    input  logic [DATA_W-1:0] enc_data,
    output logic [7:0]        s_address,
    output logic [DATA_W-1:0] s_data,
    output logic              s_wren,
    input  logic [DATA_W-1:0] s_q,
    output logic [K_W-1:0]    dec_address,
    output logic [DATA_W-1:0] dec_data,
    output logic              dec_wren,
    output logic              busy,
    output logic              done,
    output logic              key_valid
);

    rc4_state_e        state_q, state_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [K_W-1:0]    k_q, k_d;
    logic [DATA_W-1:0] si_q, si_d;
    logic [DATA_W-1:0] sj_q, sj_d;
    logic              valid_q, valid_d;

    logic [DATA_W-1:0] plain;
    logic              plain_legal;
    logic              last_byte;

    // In WT_F the RAM read data is the keystream byte f.
    assign plain = s_q ^ enc_data;

    rc4_valid_char u_valid_char (
        .char_in (plain),
        .legal   (plain_legal)
    );

`ifdef RC4_EARLY_ABORT_EN
    assign last_byte = (k_q == K_W'(MSG_LEN - 1)) || !valid_q;
`else
    assign last_byte = (k_q == K_W'(MSG_LEN - 1));
`endif

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        si_d    = si_q;
        sj_d    = sj_q;
        valid_d = valid_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    i_d     = 8'd1;
                    j_d     = 8'd0;
                    k_d     = '0;
                    valid_d = 1'b1;
                    state_d = RD_I;
                end
            end
            RD_I: state_d = WT_I;
            WT_I: begin
                si_d    = s_q;
                j_d     = j_q + s_q;
                state_d = RD_J;
            end
            RD_J: state_d = WT_J;
            WT_J: begin
                sj_d    = s_q;
                state_d = WR_J;
            end
            WR_J: state_d = WR_I;
            WR_I: state_d = RD_F;
            RD_F: state_d = WT_F;
            WT_F: begin
                valid_d = valid_q & plain_legal;
                state_d = NEXT;
            end
            NEXT: begin
                if (last_byte) begin
                    state_d = DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    k_d     = k_q + K_W'(1);
                    state_d = RD_I;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            si_q    <= '0;
            sj_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            si_q    <= si_d;
            sj_q    <= sj_d;
            valid_q <= valid_d;
        end
    end

    // RAM strobes decode straight from the state register so the read
    // data lands exactly one cycle after each RD_* address.
    always_comb begin
        s_address   = '0;
        s_data      = '0;
        s_wren      = 1'b0;
        dec_address = '0;
        dec_data    = '0;
        dec_wren    = 1'b0;
        case (state_q)
            RD_I: s_address = i_q;
            RD_J: s_address = j_q;
            WR_J: begin
                s_address = j_q;
                s_data    = si_q;
                s_wren    = 1'b1;
            end
            WR_I: begin
                s_address = i_q;
                s_data    = sj_q;
                s_wren    = 1'b1;
            end
            RD_F: s_address = si_q + sj_q;
            WT_F: begin
                dec_address = k_q;
                dec_data    = plain;
                dec_wren    = 1'b1;
            end
            default: ;
        endcase
    end

    assign enc_index = k_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign key_valid = (state_q == DONE) && valid_q;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// tb/tb_rc4_prga_decrypt.sv - directed bench for rc4_prga_decrypt with S/ciphertext/plaintext RAM models
module tb_rc4_prga_decrypt;

`ifdef RC4_EARLY_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [4:0] enc_index;
    logic [7:0] enc_data;
    logic [7:0] s_address;
    logic [7:0] s_data;
    logic       s_wren;
    logic [7:0] s_q;
    logic [4:0] dec_address;
    logic [7:0] dec_data;
    logic       dec_wren;
    logic       busy;
    logic       done;
    logic       key_valid;

    logic       init_mem;
    logic [7:0] s_mem [256];
    logic [7:0] dec_mem [32];
    logic [7:0] ct [32];
    logic [7:0] ct_ok [32];
    logic [7:0] ref_s [256];
    logic [7:0] exp_dec [32];
    int         exp_n;
    bit         exp_valid;
    int         last_lat;
    logic [7:0] peek2, peek3;
    int         total = 0;
    int         bad = 0;
    string      pt = "attack at dawn and hold the hill";

    always #5 clk = ~clk;

    rc4_prga_decrypt dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .enc_index   (enc_index),
        .enc_data    (enc_data),
        .s_address   (s_address),
        .s_data      (s_data),
        .s_wren      (s_wren),
        .s_q         (s_q),
        .dec_address (dec_address),
        .dec_data    (dec_data),
        .dec_wren    (dec_wren),
        .busy        (busy),
        .done        (done),
        .key_valid   (key_valid)
    );

    assign enc_data = ct[enc_index];

    always @(posedge clk) begin
        if (init_mem) begin
            for (int x = 0; x < 256; x++) s_mem[x] <= 8'(x);
            for (int x = 0; x < 32; x++) dec_mem[x] <= 8'h00;
        end else begin
            if (s_wren) s_mem[s_address] <= s_data;
            if (dec_wren) dec_mem[dec_address] <= dec_data;
        end
        s_q <= s_mem[s_address];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [7:0] b);
        return (b >= 8'h61 && b <= 8'h7A) || b == 8'h20;
    endfunction

    task automatic model_run(input bit allow_abort);
        logic [7:0] i, j, t, f;
        i = 8'd0;
        j = 8'd0;
        exp_valid = 1'b1;
        exp_n = 0;
        for (int k = 0; k < 32; k++) begin
            i = i + 8'd1;
            j = j + ref_s[i];
            t = ref_s[i];
            ref_s[i] = ref_s[j];
            ref_s[j] = t;
            f = ref_s[8'(ref_s[i] + ref_s[j])];
            exp_dec[k] = f ^ ct[k];
            exp_n = k + 1;
            if (!is_legal(exp_dec[k])) exp_valid = 1'b0;
            if (allow_abort && ABORT_EN && !exp_valid) break;
        end
    endtask

    task automatic init_memories();
        @(negedge clk) init_mem = 1'b1;
        @(negedge clk) init_mem = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_saddr"}, 32'(s_address), 32'd0);
        check({tag, "_sdata"}, 32'(s_data), 32'd0);
        check({tag, "_swren"}, 32'(s_wren), 32'd0);
        check({tag, "_daddr"}, 32'(dec_address), 32'd0);
        check({tag, "_ddata"}, 32'(dec_data), 32'd0);
        check({tag, "_dwren"}, 32'(dec_wren), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_kv"}, 32'(key_valid), 32'd0);
        check({tag, "_eidx"}, 32'(enc_index), 32'd0);
    endtask

    task automatic run_and_check(input string tag, input int extra_at);
        int cyc;
        int mism;
        logic [7:0] pre [32];
        for (int x = 0; x < 256; x++) ref_s[x] = s_mem[x];
        for (int x = 0; x < 32; x++) pre[x] = dec_mem[x];
        model_run(1'b1);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        check({tag, "_done_drop"}, 32'(done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start = (cyc == extra_at);
            if (cyc == 18) begin
                peek2 = s_mem[2];
                peek3 = s_mem[3];
            end
        end
        start = 1'b0;
        last_lat = cyc;
        check({tag, "_latency"}, 32'(cyc), 32'(1 + 9 * exp_n));
        check({tag, "_key_valid"}, 32'(key_valid), 32'(exp_valid));
        for (int x = 0; x < 32; x++)
            check($sformatf("%s_dec%0d", tag, x), 32'(dec_mem[x]),
                  32'((x < exp_n) ? exp_dec[x] : pre[x]));
        mism = 0;
        for (int x = 0; x < 256; x++) if (s_mem[x] !== ref_s[x]) mism++;
        check({tag, "_sram"}, 32'(mism), 32'd0);
    endtask

    initial begin
        int cyc;
        reset = 1'b1;
        start = 1'b0;
        init_mem = 1'b0;
        for (int x = 0; x < 32; x++) ct[x] = 8'h00;
        #1;
        chk_zero("reset");
        init_memories();
        @(negedge clk) reset = 1'b0;

        // keystream of the identity S box, used to build legal ciphertext
        for (int x = 0; x < 256; x++) ref_s[x] = 8'(x);
        model_run(1'b0);
        for (int x = 0; x < 32; x++) ct_ok[x] = exp_dec[x] ^ pt[x];

        // 1: identity S, all-zero ciphertext
        run_and_check("t1", -1);
        check("t1_dec0_hand", 32'(dec_mem[0]), 32'h02);
        check("t1_kv_hand", 32'(key_valid), 32'd0);
`ifndef RC4_EARLY_ABORT_EN
        check("t1_dec1_hand", 32'(dec_mem[1]), 32'h05);
        check("t1_s2_hand", 32'(peek2), 32'h03);
        check("t1_s3_hand", 32'(peek3), 32'h02);
        check("t1_lat_hand", 32'(last_lat), 32'd289);
`else
        check("t1_lat_hand", 32'(last_lat), 32'd10);
`endif

        // 2: legal plaintext
        init_memories();
        for (int x = 0; x < 32; x++) ct[x] = ct_ok[x];
        run_and_check("t2", -1);
        check("t2_kv_hand", 32'(key_valid), 32'd1);
        for (int x = 0; x < 32; x++)
            check($sformatf("t2_pt%0d", x), 32'(dec_mem[x]), 32'(pt[x]));

        // 3: byte 5 decrypts to 'A'
        init_memories();
        ct[5] = ct_ok[5] ^ pt[5] ^ 8'h41;
        run_and_check("t3", -1);
        check("t3_kv_hand", 32'(key_valid), 32'd0);
        check("t3_dec5_hand", 32'(dec_mem[5]), 32'h41);
`ifdef RC4_EARLY_ABORT_EN
        check("t3_lat_hand", 32'(last_lat), 32'd55);
        check("t3_dec6_untouched", 32'(dec_mem[6]), 32'h00);
`else
        check("t3_lat_hand", 32'(last_lat), 32'd289);
`endif

        // 4: reset during byte 10 (WR_J), then restart on the partial S
        init_memories();
        for (int x = 0; x < 32; x++) ct[x] = ct_ok[x];
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        while (cyc < 95) begin
            @(negedge clk);
            cyc++;
        end
        check("t4_pre_wren", 32'(s_wren), 32'd1);
        reset = 1'b1;
        #1;
        chk_zero("t4_rst");
        @(negedge clk) reset = 1'b0;
        run_and_check("t4_restart", -1);

        // 5: start pulse during byte 3 is ignored
        init_memories();
        run_and_check("t5", 30);
        check("t5_kv_hand", 32'(key_valid), 32'd1);
        check("t5_lat_hand", 32'(last_lat), 32'd289);

        // 6: restart from DONE with different ciphertext
        for (int x = 0; x < 32; x++) ct[x] = 8'h00;
        run_and_check("t6", -1);
        check("t6_done_hold", 32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
